sw_feeder: RTL and testbench
============================

// Module: sw_feeder
// PURPOSE
//  Upstream driver of the Smith-Waterman systolic PE chain. Buffers the database T, loads
//  query S in NPE-char blocks, streams T into PE0 with init/changeS framing, and feeds the
//  last PE's V/F back as PE0's V/F on later passes. Tracks the global best score from the
//  chain tail.
// PARAMETERS
//  NPE      16       PEs in chain; query block size
//  TLEN_MAX 256      max T length; depth of T and feedback buffers
//  W        12       score width, signed two's complement
//  NEG_INF  12'h900  approximate -infinity for the first pass F
// PORTS
//  clk        in  1        clock, rising edge
//  rst        in  1        reset; synchronous, active-high
//  start      in  1        begin job; sampled in IDLE only
//  s_len      in  8        query length in chars; nonzero multiple of NPE
//  t_len      in  9        database length, 1..TLEN_MAX
//  t_valid/t_ready  in/out 1   T char handshake
//  t_data     in  2        T char
//  s_valid/s_ready  in/out 1   S char handshake
//  s_data     in  2        S char
//  pe_changeS out 1        to PE0 changeS_in
//  pe_S       out 2*NPE    per-PE S bus; PE k uses bits [2k+1:2k]
//  pe_T       out 2        to PE0 T_in
//  pe_MAX     out W        to PE0 MAX_in; constant 0
//  pe_V/pe_F  out W        to PE0 V_in/F_in
//  pe_init    out 1        to PE0 init_in
//  tail_V/tail_F/tail_MAX in W  last PE V_out/F_out/MAX_out
//  tail_init  in  1        last PE init_out
//  busy       out 1        high outside IDLE
//  done       out 1        one-cycle pulse at job end
//  score      out W        best score; valid from done until next start
//  err        out 1        one-cycle pulse on rejected start
// BEHAVIOUR
//  - Reset: state IDLE. All outputs 0 except pe_F = NEG_INF. Pointers/pass counter cleared.
//    Buffers not cleared.
//  - Reset mid-job aborts immediately. No done pulse.
//  - IDLE: start with bad s_len/t_len -> err pulse next cycle, stay IDLE.
//    Valid start -> LOADT; clear score, pass=0.
//  - LOADT: t_ready=1. Each t_valid&t_ready writes t_mem[idx]. After t_len accepts -> LOADS.
//  - LOADS: s_ready=1. NPE accepts shift into pe_S; the first char lands at PE0.
//    After NPE accepts -> STREAM. pe_S holds stable until next LOADS.
//  - STREAM: exactly t_len cycles, no bubbles; pe_init=1, pe_T=t_mem[j], j=0..t_len-1.
//    pe_changeS=1 only when j=0.
//    Pass 0: pe_V=0, pe_F=NEG_INF. Pass p>0: pe_V/pe_F = fb_mem[j].
//  - DRAIN: exactly NPE cycles; pe_init=0, pe_T=0, pe_V=0, pe_F=NEG_INF.
//    Then, if (pass+1)*NPE < s_len: pass++ -> LOADS. Else DONE.
//  - Tail capture, any state: on tail_init=1, write {tail_V,tail_F} to fb_mem[wp]; wp++.
//    Also score <= max(score, tail_MAX) (signed compare). wp resets to 0 each STREAM entry.
//    Read index j always leads wp by NPE, so read-before-write on one buffer is safe.
//  - DONE: done=1 for one cycle -> IDLE. score holds until next valid start.
//  - start while busy is ignored. s_valid/t_valid outside their load state is ignored.
//  - All pe_* outputs are registered: first STREAM cycle = first cycle pe_init=1.
// CONFIGURATION
//  SW_MULTIPASS_EN defined: multi-pass as above; s_len in {NPE, 2*NPE, ..., floor(255/NPE)*NPE}.
//  SW_MULTIPASS_EN undefined: fb_mem and pass counter omitted; s_len must equal NPE, else err.
//    One pass only; pe_V=0 and pe_F=NEG_INF always; tail_V/tail_F ignored.
// TESTING
//  1 rst held 3 cycles mid-STREAM -> next cycle IDLE, pe_init=0, pe_F=12'h900, busy=0,
//    no done pulse.
//  2 start, s_len=5 -> err pulse 1 cycle; busy stays 0.
//  3 NPE=4, S=ACGT, T=ACGT, t_len=4, chain of PEs -> pe_init high 4 cycles;
//    pe_changeS only on first; done after 4+4 cycles; score=match*4.
//  4 t_valid toggling 1/0 during LOADT -> t_mem holds exact T order;
//    STREAM still t_len gap-free cycles.
//  5 [MULTIPASS] NPE=4, s_len=8, t_len=6 -> two STREAM windows; pass-1 pe_V/pe_F equal
//    pass-0 tail_V/tail_F per column; score matches 8x6 reference model.
//  6 start asserted during STREAM -> ignored; score and pass count unaffected.

Source files
------------

// File: rtl/sw_feeder.sv
// sw_feeder: buffers T, loads S blocks and streams T into a Smith-Waterman PE chain; define SW_MULTIPASS_EN for multi-pass queries
module sw_feeder #(
  parameter int NPE = 16,
  parameter int TLEN_MAX = 256,
  parameter int W = 12,
  parameter logic [W-1:0] NEG_INF = 12'h900
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       s_len,
  input  logic [8:0]       t_len,
  input  logic             t_valid,
  output logic             t_ready,
  input  logic [1:0]       t_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_data,
  output logic             pe_changeS,
  output logic [2*NPE-1:0] pe_S,
  output logic [1:0]       pe_T,
  output logic [W-1:0]     pe_MAX,
  output logic [W-1:0]     pe_V,
  output logic [W-1:0]     pe_F,
  output logic             pe_init,
  input  logic [W-1:0]     tail_V,
  input  logic [W-1:0]     tail_F,
  input  logic [W-1:0]     tail_MAX,
  input  logic             tail_init,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     score,
  output logic             err
);
  localparam int AW = $clog2(TLEN_MAX);
  localparam logic [7:0] NPE8 = 8'(NPE);
  localparam logic [8:0] NPE9 = 9'(NPE);
  localparam logic [8:0] TMAX = 9'(TLEN_MAX);
  typedef enum logic [2:0] {IDLE, LOADT, LOADS, STREAM, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [8:0] cnt, cnt_n, tl;
  logic [1:0] t_mem [TLEN_MAX];
  logic ok, go, step, wrap, more, strm_n;
  logic [AW-1:0] ri;
`ifdef SW_MULTIPASS_EN
  assign ok = s_len != 8'd0 && s_len % NPE8 == 8'd0 && t_len != 9'd0 && t_len <= TMAX;
`else
  assign ok = s_len == NPE8 && t_len != 9'd0 && t_len <= TMAX;
`endif
  assign go = state == IDLE && start && ok;
  assign step = state == LOADT ? t_valid : state == LOADS ? s_valid : state == STREAM || state == DRAIN;
  assign wrap = step && cnt + 9'd1 == ((state == LOADS || state == DRAIN) ? NPE9 : tl);
  assign cnt_n = (state == IDLE || wrap) ? 9'd0 : cnt + {8'd0, step};
  assign strm_n = state_n == STREAM;
  assign ri = cnt_n[AW-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign t_ready = state == LOADT;
  assign s_ready = state == LOADS;
  assign pe_MAX = '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = LOADT;
      LOADT:   if (wrap) state_n = LOADS;
      LOADS:   if (wrap) state_n = STREAM;
      STREAM:  if (wrap) state_n = DRAIN;
      DRAIN:   if (wrap) state_n = more ? LOADS : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (t_ready && t_valid) t_mem[cnt[AW-1:0]] <= t_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tl <= '0;
      pe_S <= '0;
      pe_T <= '0;
      pe_init <= 1'b0;
      pe_changeS <= 1'b0;
      score <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      err <= state == IDLE && start && !ok;
      pe_init <= strm_n;
      pe_changeS <= strm_n && cnt_n == 9'd0;
      pe_T <= strm_n ? t_mem[ri] : 2'd0;
      if (go) tl <= t_len;
      // newest char enters at the top so the first char ends up at PE0
      if (s_ready && s_valid) pe_S <= {s_data, pe_S[2*NPE-1:2]};
      if (go) score <= '0;
      else if (tail_init && $signed(tail_MAX) > $signed(score)) score <= tail_MAX;
    end
  end
`ifdef SW_MULTIPASS_EN
  logic [7:0] pass, sl;
  logic [AW-1:0] wp;
  logic [2*W-1:0] fb_mem [TLEN_MAX];
  assign more = (16'(pass) + 16'd1) * 16'(NPE) < 16'(sl);
  always_ff @(posedge clk)
    if (tail_init) fb_mem[wp] <= {tail_V, tail_F};
  // reads lead the tail writes by the chain depth, so one buffer serves both passes
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= '0;
      sl <= '0;
      wp <= '0;
      pe_V <= '0;
      pe_F <= NEG_INF;
    end else begin
      if (go) begin
        pass <= '0;
        sl <= s_len;
      end else if (state == DRAIN && wrap && more) pass <= pass + 8'd1;
      wp <= (strm_n && state != STREAM) ? '0 : wp + AW'(tail_init);
      pe_V <= (strm_n && pass != 8'd0) ? fb_mem[ri][2*W-1:W] : '0;
      pe_F <= (strm_n && pass != 8'd0) ? fb_mem[ri][W-1:0] : NEG_INF;
    end
  end
`else
  logic unused;
  assign more = 1'b0;
  assign pe_V = '0;
  assign pe_F = NEG_INF;
  assign unused = ^{tail_V, tail_F};
`endif
endmodule

// File: tb/tb_sw_feeder.sv
// tb_sw_feeder: table-driven and randomized checks of sw_feeder against a delayed chain-tail model
module tb_sw_feeder;
  localparam int NPE = 4;
  localparam int TL = 256;
  localparam int W = 12;
  localparam logic [W-1:0] NI = 12'h900;
`ifdef SW_MULTIPASS_EN
  localparam bit MP = 1'b1;
`else
  localparam bit MP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, t_valid = 1'b0, s_valid = 1'b0, tail_init = 1'b0;
  logic [7:0] s_len = '0;
  logic [8:0] t_len = '0;
  logic [1:0] t_data = '0, s_data = '0;
  logic [W-1:0] tail_V = '0, tail_F = '0, tail_MAX = '0;
  logic t_ready, s_ready, pe_changeS, pe_init, busy, done, err;
  logic [2*NPE-1:0] pe_S;
  logic [1:0] pe_T;
  logic [W-1:0] pe_MAX, pe_V, pe_F, score;

  sw_feeder #(.NPE(NPE), .TLEN_MAX(TL), .W(W), .NEG_INF(NI)) dut (
    .clk(clk), .rst(rst), .start(start), .s_len(s_len), .t_len(t_len),
    .t_valid(t_valid), .t_ready(t_ready), .t_data(t_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pe_changeS(pe_changeS), .pe_S(pe_S), .pe_T(pe_T), .pe_MAX(pe_MAX),
    .pe_V(pe_V), .pe_F(pe_F), .pe_init(pe_init),
    .tail_V(tail_V), .tail_F(tail_F), .tail_MAX(tail_MAX), .tail_init(tail_init),
    .busy(busy), .done(done), .score(score), .err(err)
  );

  initial forever #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [1:0] T [TL];
  logic [1:0] S [256];
  int jtl = 0;

  // chain model: tail echoes pe_init NPE cycles later with random V/F/MAX
  logic dl_i [NPE];
  logic dl_c [NPE];
  logic [2*W-1:0] tv [16][TL];
  logic [W-1:0] exp_sc = '0;
  int spass = -1, col = 0, tpass = -1, tcol = 0, ninit = 0;
  initial begin
    logic prev_init, prev_busy, ti, tc;
    logic [2*NPE-1:0] es;
    logic [2*W-1:0] ev;
    prev_init = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < NPE; i++) begin
      dl_i[i] = 1'b0;
      dl_c[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        spass = -1; tpass = -1; col = 0; tcol = 0; ninit = 0; exp_sc = '0;
      end
      if (!rst && pe_init) begin
        if (!prev_init) begin
          spass++;
          col = 0;
          for (int k = 0; k < NPE; k++) es[2*k +: 2] = S[(spass * NPE + k) % 256];
          chk("pe_S", 64'(pe_S), 64'(es));
        end
        ev = spass > 0 ? tv[(spass - 1) % 16][col % TL] : {{W{1'b0}}, NI};
        chk("stream", {pe_changeS, pe_T, pe_V, pe_F}, {col == 0, T[col % TL], ev});
        col++;
        ninit++;
      end
      if (!rst && prev_init && !pe_init) chk("window_len", 64'(col), 64'(jtl));
      ti = dl_i[NPE-1];
      tc = dl_c[NPE-1];
      for (int i = NPE - 1; i > 0; i--) begin
        dl_i[i] = dl_i[i-1];
        dl_c[i] = dl_c[i-1];
      end
      dl_i[0] = pe_init && !rst;
      dl_c[0] = pe_init && !prev_init && !rst;
      if (rst) for (int i = 0; i < NPE; i++) begin
        dl_i[i] = 1'b0;
        dl_c[i] = 1'b0;
      end
      prev_init = pe_init;
      prev_busy = busy;
      tail_init = ti && !rst;
      tail_V = W'($urandom);
      tail_F = W'($urandom);
      tail_MAX = W'($urandom);
      if (tail_init) begin
        if (tc) begin
          tpass++;
          tcol = 0;
        end
        tv[tpass % 16][tcol % TL] = {tail_V, tail_F};
        tcol++;
        if ($signed(tail_MAX) > $signed(exp_sc)) exp_sc = tail_MAX;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic job(input int sl, input int tl, input bit gaps, input bit poke, input bit abort);
    int ti, si, lat, np;
    bit got, tvd, svd, tr, sr;
    ti = 0; si = 0; lat = 0; got = 1'b0; np = sl / NPE;
    jtl = tl;
    for (int i = 0; i < tl; i++) T[i] = 2'($urandom);
    for (int i = 0; i < sl; i++) S[i] = 2'($urandom);
    @(negedge clk);
    start = 1'b1;
    s_len = 8'(sl);
    t_len = 9'(tl);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start = poke && pe_init;
      if (start) begin
        s_len = 8'($urandom);
        t_len = 9'($urandom);
      end
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
      if (abort && pe_init && !pe_changeS) break;
      tr = t_ready;
      sr = s_ready;
      tvd = !gaps || $urandom_range(1) == 1;
      svd = !gaps || $urandom_range(1) == 1;
      t_valid = tvd;
      s_valid = svd;
      t_data = T[ti % TL];
      s_data = S[si % 256];
      @(posedge clk);
      if (tvd && tr) ti++;
      if (svd && sr) si++;
    end
    t_valid = 1'b0;
    s_valid = 1'b0;
    start = 1'b0;
    if (!abort) begin
      chk("done_seen", 64'(got), 64'd1);
      if (!gaps) chk("latency", 64'(lat), 64'(tl + np * (2 * NPE + tl)));
      chk("passes", 64'(spass + 1), 64'(np));
      chk("stream_cycles", 64'(ninit), 64'(np * tl));
      chk("score", 64'(score), 64'(exp_sc));
      @(negedge clk);
      chk("done_pulse", {done, busy, score}, {2'b00, exp_sc});
      if (!got) do_reset();
    end
  endtask

  typedef struct { logic [7:0] sl; logic [8:0] tl; bit bad; } vec_t;
  vec_t vt [10];
  localparam logic [44:0] RST_EXP = {9'd0, 12'd0, NI, 12'd0};
  function automatic logic [44:0] rvec();
    return {busy, done, err, pe_init, pe_changeS, t_ready, s_ready, pe_T, pe_V, pe_F, pe_MAX};
  endfunction

  initial begin
    vt[0] = '{8'd5, 9'd4, 1'b1};
    vt[1] = '{8'd0, 9'd4, 1'b1};
    vt[2] = '{8'd4, 9'd0, 1'b1};
    vt[3] = '{8'd4, 9'd257, 1'b1};
    vt[4] = '{8'd6, 9'd4, 1'b1};
    vt[5] = '{8'd8, 9'd4, !MP};
    vt[6] = '{8'd4, 9'd256, 1'b0};
    vt[7] = '{8'd4, 9'd1, 1'b0};
    vt[8] = '{8'd252, 9'd9, !MP};
    vt[9] = '{8'd255, 9'd4, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(rvec()), 64'(RST_EXP));
    chk("reset_s_score", {pe_S, score}, '0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b1;
      s_len = vt[i].sl;
      t_len = vt[i].tl;
      @(negedge clk);
      start = 1'b0;
      chk("start_err", {err, busy}, {vt[i].bad, !vt[i].bad});
      @(negedge clk);
      chk("err_pulse", {err, busy}, {1'b0, !vt[i].bad});
      if (!vt[i].bad) do_reset();
    end
    job(NPE, 4, 1'b0, 1'b0, 1'b0);
    job(NPE, 12, 1'b1, 1'b0, 1'b0);
    job(NPE, 1, 1'b0, 1'b0, 1'b0);
    job(NPE, 256, 1'b0, 1'b0, 1'b0);
    job(NPE, 20, 1'b0, 1'b1, 1'b0);
`ifdef SW_MULTIPASS_EN
    job(2 * NPE, 6, 1'b0, 1'b0, 1'b0);
    job(4 * NPE, 9, 1'b1, 1'b1, 1'b0);
    job(3 * NPE, 2, 1'b0, 1'b0, 1'b0);
`endif
    for (int k = 0; k < 10; k++)
      job(MP ? NPE * $urandom_range(1, 4) : NPE, $urandom_range(1, 40), $urandom_range(1) == 1, $urandom_range(1) == 1, 1'b0);
    job(NPE, 10, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_outputs", 64'(rvec()), 64'(RST_EXP));
    end
    chk("abort_s_score", {pe_S, score}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, done, err}, 3'b000);
    job(NPE, 5, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
